// File: rtl/west_input_buffer_pkg.sv
// Shared NoC definitions for the West input buffer: flit type codes, flit width,
// output-port one-hot indices, FSM state encoding and flit classification helpers.
package west_input_buffer_pkg;

    localparam int NOC_FLIT_W = 8;
    localparam int NUM_PORTS  = 5;

    localparam int PORT_L = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_N = 4;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HDR    = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DROP   = 2'b10
    } ib_state_t;

    function automatic flit_type_t flit_type(input logic [NOC_FLIT_W-1:0] flit);
        return flit_type_t'(flit[NOC_FLIT_W-1 -: 2]);
    endfunction

    function automatic logic opens_packet(input flit_type_t ft);
        return (ft == FT_HDR) || (ft == FT_SINGLE);
    endfunction

    function automatic logic closes_packet(input flit_type_t ft);
        return (ft == FT_TAIL) || (ft == FT_SINGLE);
    endfunction

endpackage

// File: rtl/west_input_buffer_if.sv
// Signal bundle between the West input buffer and its neighbours: link, routing
// logic, switch allocator and crossbar.
interface west_input_buffer_if;
    import west_input_buffer_pkg::*;

    logic [NOC_FLIT_W-1:0] flit_in;
    logic                  flit_in_valid;
    logic                  flit_in_ready;
    logic [NOC_FLIT_W-1:0] head_flit;
    logic                  rt_e1;
    logic                  rt_e2;
    logic                  rt_e3;
    logic                  rt_e4;
    logic                  rt_e5;
    logic [NUM_PORTS-1:0]  req;
    logic                  grant;
    logic [NOC_FLIT_W-1:0] flit_out;
    logic                  flit_out_valid;
    logic                  err_drop;

    modport slave (
        input  flit_in, flit_in_valid, rt_e1, rt_e2, rt_e3, rt_e4, rt_e5, grant,
        output flit_in_ready, head_flit, req, flit_out, flit_out_valid, err_drop
    );

    modport master (
        output flit_in, flit_in_valid, rt_e1, rt_e2, rt_e3, rt_e4, rt_e5, grant,
        input  flit_in_ready, head_flit, req, flit_out, flit_out_valid, err_drop
    );

endinterface

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with occupancy count; the head is read straight from storage
// so a flit pushed into an empty FIFO shows up on the cycle after the push.
module noc_flit_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [W-1:0]   din,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output logic [W-1:0]   head,
    output logic [PTR_W:0] count
);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + (PTR_W+1)'(do_push_s) - (PTR_W+1)'(do_pop_s);
        end
    end

    assign full  = (count_r == (PTR_W+1)'(DEPTH));
    assign empty = (count_r == '0);
    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/west_input_buffer.sv
// West input port: buffers link flits, latches the routing decision for a whole
// wormhole packet, requests the allocator and forwards granted flits to the crossbar.
module west_input_buffer
    import west_input_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int FLIT_W = NOC_FLIT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    west_input_buffer_if.slave  bus
);

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [FLIT_W-1:0]    head_s;
    logic [PTR_W:0]       count_s;
    logic [PTR_W:0]       count_next_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fwd_s;
    logic                 drop_s;
    flit_type_t           head_type_s;
    logic [NUM_PORTS-1:0] route_in_s;

    ib_state_t            state_r;
    ib_state_t            state_next_s;
    logic [NUM_PORTS-1:0] route_r;
    logic [NUM_PORTS-1:0] route_next_s;
    logic [NUM_PORTS-1:0] req_r;
    logic [FLIT_W-1:0]    flit_out_r;
    logic                 flit_out_valid_r;
    logic                 err_drop_r;

    assign push_s      = bus.flit_in_valid && !fifo_full_s;
    assign route_in_s  = {bus.rt_e5, bus.rt_e4, bus.rt_e3, bus.rt_e2, bus.rt_e1};
    assign head_type_s = flit_type(head_s);

    noc_flit_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (bus.flit_in),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s),
        .count (count_s)
    );

    // Next-state, pop and forward/drop decisions for the wormhole FSM.
    always_comb begin
        state_next_s = state_r;
        route_next_s = route_r;
        pop_s        = 1'b0;
        fwd_s        = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fifo_empty_s) begin
                    state_next_s = ST_IDLE;
                end else if (opens_packet(head_type_s)) begin
                    if (route_in_s != '0) begin
                        route_next_s = route_in_s;
                        state_next_s = ST_ACTIVE;
                    end else begin
                        // Undefined destination: discard the header and the rest of its packet.
                        pop_s  = 1'b1;
                        drop_s = 1'b1;
                        if (head_type_s == FT_HDR) begin
                            state_next_s = ST_DROP;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end
                end else begin
                    pop_s        = 1'b1;
                    drop_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.grant && (req_r != '0) && !fifo_empty_s) begin
                    pop_s = 1'b1;
                    fwd_s = 1'b1;
                    if (closes_packet(head_type_s)) begin
                        route_next_s = '0;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_ACTIVE;
                    end
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            ST_DROP: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (head_type_s == FT_TAIL) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DROP;
                    end
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                route_next_s = '0;
            end
        endcase
    end

    assign count_next_s = count_s + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);

    // Registered FSM state, route latch and every output toward allocator and crossbar.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            route_r          <= '0;
            req_r            <= '0;
            flit_out_r       <= '0;
            flit_out_valid_r <= 1'b0;
            err_drop_r       <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            route_r          <= route_next_s;
            // req tracks the FIFO occupancy the allocator will see next cycle.
            req_r            <= ((state_next_s == ST_ACTIVE) && (count_next_s != '0)) ?
                                route_next_s : '0;
            flit_out_valid_r <= fwd_s;
            if (fwd_s) begin
                flit_out_r <= head_s;
            end
            if (drop_s) begin
                err_drop_r <= 1'b1;
            end
        end
    end

    assign bus.flit_in_ready  = !fifo_full_s;
    assign bus.head_flit      = head_s;
    assign bus.req            = req_r;
    assign bus.flit_out       = flit_out_r;
    assign bus.flit_out_valid = flit_out_valid_r;
    assign bus.err_drop       = err_drop_r;

endmodule
